lsu_mem_ctrl: RTL and testbench

//  Load/store unit memory controller: arbitrates the single data-memory port between the load

---
 rtl/lsu_mem_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory controller: arbitrates one data-memory port between loads and committed
// stores, formats sub-word accesses and squashes flushed loads.
package lsu_mem_pkg;
  typedef enum logic [2:0] {
    mem_lb, mem_lbu, mem_lh, mem_lhu, mem_lw, mem_sb, mem_sh, mem_sw
  } mem_ops;
endpackage

module lsu_mem_ctrl
  import lsu_mem_pkg::*;
#(
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  mem_ops           ld_memop,
  input  logic [31:0]      ld_addr,
  input  logic [TAG_W-1:0] ld_tag,
  input  logic             st_valid,
  output logic             st_ready,
  input  mem_ops           st_memop,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_wdata,
  input  logic             flush,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [31:0]      dmem_address,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_byte_enable,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_resp,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data,
  output logic             res_misaligned,
  output logic             st_misaligned
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // state | meaning: IDLE arbitrate | LOAD read pending | STORE write pending | RESULT load writeback
  typedef enum logic [1:0] {IDLE, LOAD, STORE, RESULT} state_e;

  state_e             state_q, state_d;
  mem_ops             op_q, op_d;
  logic [31:0]        addr_q, addr_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               mis_q, mis_d;
  logic               squash_q, squash_d;
  logic               st_mis_q, st_mis_d;
  logic [CNT_W-1:0]   starve_q, starve_d;

  logic grant_ld, grant_st, ld_mis, st_mis, in_idle, active;

  function automatic logic is_misaligned(input mem_ops op, input logic [1:0] a);
    case (op)
      mem_lh, mem_lhu, mem_sh: return a[0];
      mem_lw, mem_sw:          return (a != 2'b00);
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input mem_ops op, input logic [1:0] a);
    case (op)
      mem_lw, mem_sw:          return 4'b1111;
      mem_lh, mem_lhu, mem_sh: return 4'b0011 << {a[1], 1'b0};
      default:                 return 4'b0001 << a;
    endcase
  endfunction

  function automatic logic [31:0] shift_wdata(input mem_ops op, input logic [1:0] a,
                                              input logic [31:0] d);
    case (op)
      mem_sb:  return d << {a, 3'b000};
      mem_sh:  return d << {a[1], 4'b0000};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input mem_ops op, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = 16'(d >> {a[1], 4'b0000});
    case (op)
      mem_lb:  return {{24{b[7]}}, b};
      mem_lbu: return {24'b0, b};
      mem_lh:  return {{16{h[15]}}, h};
      mem_lhu: return {16'b0, h};
      default: return d;
    endcase
  endfunction

  assign in_idle  = (state_q == IDLE) && rst_n;
  assign ld_mis   = is_misaligned(ld_memop, ld_addr[1:0]);
  assign st_mis   = is_misaligned(st_memop, st_addr[1:0]);
  // A waiting load only overtakes a store once it has been passed over STARVE_LIMIT times.
  assign grant_ld = in_idle && ld_valid && !flush &&
                    (!st_valid || (starve_q == CNT_W'(STARVE_LIMIT)));
  assign grant_st = in_idle && st_valid && !grant_ld;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    tag_d    = tag_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    st_mis_d = 1'b0;
    starve_d = starve_q;

    case (state_q)
      IDLE: begin
        if (grant_ld) begin
          op_d    = ld_memop;
          addr_d  = ld_addr;
          tag_d   = ld_tag;
          be_d    = byte_en(ld_memop, ld_addr[1:0]);
          wdata_d = '0;
          rdata_d = '0;
          mis_d   = ld_mis;
          state_d = ld_mis ? RESULT : LOAD;
        end else if (grant_st) begin
          op_d     = st_memop;
          addr_d   = st_addr;
          be_d     = byte_en(st_memop, st_addr[1:0]);
          wdata_d  = shift_wdata(st_memop, st_addr[1:0], st_wdata);
          st_mis_d = st_mis;
          state_d  = st_mis ? IDLE : STORE;
        end
      end
      LOAD: begin
        if (dmem_resp) begin
          rdata_d = fmt_load(op_q, addr_q[1:0], dmem_rdata);
          state_d = RESULT;
        end
      end
      STORE:   if (dmem_resp) state_d = IDLE;
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (grant_ld || !ld_valid) begin
      starve_d = '0;
    end else if (grant_st && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end

    // Squash only ever marks a load that is already in flight; it dies on return to IDLE.
    squash_d = (state_d == IDLE) ? 1'b0 : (squash_q || ((state_q == LOAD) && flush));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= mem_lb;
      addr_q   <= '0;
      tag_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      squash_q <= 1'b0;
      st_mis_q <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      squash_q <= squash_d;
      st_mis_q <= st_mis_d;
      starve_q <= starve_d;
    end
  end

  assign active           = (state_q == LOAD) || (state_q == STORE);
  assign ld_ready         = grant_ld;
  assign st_ready         = grant_st;
  assign dmem_read        = (state_q == LOAD);
  assign dmem_write       = (state_q == STORE);
  assign dmem_address     = active ? {addr_q[31:2], 2'b00} : '0;
  assign dmem_wdata       = (state_q == STORE) ? wdata_q : '0;
  assign dmem_byte_enable = active ? be_q : '0;
  assign res_valid        = (state_q == RESULT) && !squash_q && !flush;
  assign res_tag          = res_valid ? tag_q : '0;
  assign res_data         = res_valid ? rdata_q : '0;
  assign res_misaligned   = res_valid && mis_q;
  assign st_misaligned    = st_mis_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: formatted loads/stores, arbitration fairness,
// misalignment, flush squashing and reset during an access.
module tb_lsu_mem_ctrl;
  import lsu_mem_pkg::*;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ld_valid, ld_ready;
  mem_ops           ld_memop;
  logic [31:0]      ld_addr;
  logic [TAG_W-1:0] ld_tag;
  logic             st_valid, st_ready;
  mem_ops           st_memop;
  logic [31:0]      st_addr, st_wdata;
  logic             flush;
  logic             dmem_read, dmem_write;
  logic [31:0]      dmem_address, dmem_wdata, dmem_rdata;
  logic [3:0]       dmem_byte_enable;
  logic             dmem_resp;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_data;
  logic             res_misaligned, st_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_ctrl #(.TAG_W(TAG_W), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_memop(ld_memop), .ld_addr(ld_addr),
    .ld_tag(ld_tag),
    .st_valid(st_valid), .st_ready(st_ready), .st_memop(st_memop), .st_addr(st_addr),
    .st_wdata(st_wdata), .flush(flush),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .res_misaligned(res_misaligned), .st_misaligned(st_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"},
             {ld_ready, st_ready, dmem_read, dmem_write, res_valid, res_misaligned,
              st_misaligned, dmem_byte_enable, res_tag}, 32'h0);
    check_eq({tag, "_addr"},  dmem_address, 32'h0);
    check_eq({tag, "_wdata"}, dmem_wdata, 32'h0);
    check_eq({tag, "_rdata"}, res_data, 32'h0);
  endtask

  task automatic do_load(input mem_ops op, input logic [31:0] addr, input logic [3:0] tag,
                         input logic [31:0] rdata, input int lat,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    @(negedge clk);
    ld_valid = 1'b1; ld_memop = op; ld_addr = addr; ld_tag = tag;
    #1 check_eq("ld_ready", ld_ready, 1);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      ld_valid   = 1'b0;
      dmem_resp  = (i == lat);
      dmem_rdata = rdata;
      #1;
      check_eq("ld_read_held", dmem_read, 1);
      check_eq("ld_address", dmem_address, {addr[31:2], 2'b00});
      check_eq("ld_be", dmem_byte_enable, exp_be);
    end
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    check_eq("ld_res_valid", res_valid, 1);
    check_eq("ld_res_data", res_data, exp_data);
    check_eq("ld_res_tag", res_tag, tag);
    check_eq("ld_res_mis", res_misaligned, 0);
    check_eq("ld_read_drop", dmem_read, 0);
    @(negedge clk);
    #1 check_eq("ld_res_pulse", res_valid, 0);
  endtask

  task automatic do_store(input mem_ops op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int lat, input logic [31:0] exp_wdata, input logic [3:0] exp_be);
    @(negedge clk);
    st_valid = 1'b1; st_memop = op; st_addr = addr; st_wdata = wdata;
    #1 check_eq("st_ready", st_ready, 1);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      st_valid  = 1'b0;
      dmem_resp = (i == lat);
      #1;
      check_eq("st_write_held", dmem_write, 1);
      check_eq("st_address", dmem_address, {addr[31:2], 2'b00});
      check_eq("st_wdata", dmem_wdata, exp_wdata);
      check_eq("st_be", dmem_byte_enable, exp_be);
    end
    @(negedge clk);
    dmem_resp = 1'b0;
    #1 check_eq("st_write_drop", dmem_write, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ng;
    rst_n = 1'b0; ld_valid = 1'b0; st_valid = 1'b0; flush = 1'b0; dmem_resp = 1'b0;
    ld_memop = mem_lb; ld_addr = '0; ld_tag = '0;
    st_memop = mem_sb; st_addr = '0; st_wdata = '0; dmem_rdata = '0;
    repeat (3) @(negedge clk);
    #1 check_quiet("reset");
    rst_n = 1'b1;

    do_load(mem_lb,  32'h0000_0103, 4'h5, 32'h80FF_FF00, 2, 4'b1000, 32'hFFFF_FF80);
    do_load(mem_lhu, 32'h0000_00A2, 4'h6, 32'h8001_1234, 1, 4'b1100, 32'h0000_8001);
    do_load(mem_lbu, 32'h0000_0301, 4'h7, 32'h1234_F6AB, 1, 4'b0010, 32'h0000_00F6);
    do_load(mem_lw,  32'h0000_0400, 4'h8, 32'hCAFE_F00D, 3, 4'b1111, 32'hCAFE_F00D);
    do_store(mem_sh, 32'h0000_0202, 32'h0000_BEEF, 3, 32'hBEEF_0000, 4'b1100);
    do_store(mem_sb, 32'h0000_0101, 32'h0000_00A5, 1, 32'h0000_A500, 4'b0010);
    do_store(mem_sw, 32'h0000_0050, 32'h1234_5678, 2, 32'h1234_5678, 4'b1111);

    // Both requesters always valid: four stores then one load, repeating.
    ld_memop = mem_lw; ld_addr = 32'h10; ld_tag = 4'h2;
    st_memop = mem_sw; st_addr = 32'h20; st_wdata = 32'h5A5A_5A5A;
    ng = 0;
    for (int cyc = 0; cyc < 200 && ng < 10; cyc++) begin
      @(negedge clk);
      ld_valid = 1'b1; st_valid = 1'b1; dmem_resp = 1'b0;
      #1;
      dmem_resp = dmem_read | dmem_write;
      if (ld_ready || st_ready) begin
        check_eq("arb_exclusive", ld_ready & st_ready, 0);
        check_eq($sformatf("arb_grant%0d_is_load", ng), ld_ready, (ng % 5 == 4));
        ng++;
      end
    end
    check_eq("arb_grant_count", ng, 10);
    @(negedge clk); ld_valid = 1'b0; st_valid = 1'b0; dmem_resp = 1'b1;
    @(negedge clk); dmem_resp = 1'b0;
    @(negedge clk);

    // Misaligned load: no memory access, flagged result next cycle.
    ld_valid = 1'b1; ld_memop = mem_lw; ld_addr = 32'h101; ld_tag = 4'h9;
    #1 check_eq("mis_ld_ready", ld_ready, 1);
    @(negedge clk); ld_valid = 1'b0;
    #1;
    check_eq("mis_ld_no_read", dmem_read, 0);
    check_eq("mis_ld_res_valid", res_valid, 1);
    check_eq("mis_ld_flag", res_misaligned, 1);
    check_eq("mis_ld_data", res_data, 0);
    check_eq("mis_ld_tag", res_tag, 4'h9);
    @(negedge clk);
    #1 check_eq("mis_ld_pulse", res_valid, 0);

    // Misaligned store: dropped with a one-cycle flag.
    st_valid = 1'b1; st_memop = mem_sw; st_addr = 32'h22; st_wdata = 32'h1111_2222;
    #1 check_eq("mis_st_ready", st_ready, 1);
    @(negedge clk); st_valid = 1'b0;
    #1;
    check_eq("mis_st_flag", st_misaligned, 1);
    check_eq("mis_st_no_write", dmem_write, 0);
    @(negedge clk);
    #1 check_eq("mis_st_pulse", st_misaligned, 0);

    // Flush one cycle after grant: read still held to resp, no result.
    ld_valid = 1'b1; ld_memop = mem_lw; ld_addr = 32'h40; ld_tag = 4'h3;
    #1 check_eq("fl_ld_ready", ld_ready, 1);
    @(negedge clk); ld_valid = 1'b0; flush = 1'b1;
    #1 check_eq("fl_read_c1", dmem_read, 1);
    @(negedge clk); flush = 1'b0;
    #1 check_eq("fl_read_c2", dmem_read, 1);
    @(negedge clk);
    #1 check_eq("fl_read_c3", dmem_read, 1);
    @(negedge clk); dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
    #1 check_eq("fl_read_c4", dmem_read, 1);
    @(negedge clk); dmem_resp = 1'b0;
    #1;
    check_eq("fl_no_res", res_valid, 0);
    check_eq("fl_read_drop", dmem_read, 0);
    @(negedge clk);
    #1 check_eq("fl_no_res_late", res_valid, 0);

    // Flush in IDLE blocks the load; flush in RESULT suppresses its pulse.
    ld_valid = 1'b1; ld_memop = mem_lw; ld_addr = 32'h44; ld_tag = 4'h4; flush = 1'b1;
    #1 check_eq("fl_idle_block", ld_ready, 0);
    flush = 1'b0;
    #1 check_eq("fl_idle_release", ld_ready, 1);
    @(negedge clk); ld_valid = 1'b0; dmem_resp = 1'b1;
    #1 check_eq("fl_res_read", dmem_read, 1);
    @(negedge clk); dmem_resp = 1'b0; flush = 1'b1;
    #1 check_eq("fl_res_suppress", res_valid, 0);
    @(negedge clk); flush = 1'b0;

    // Stray resp while idle is ignored.
    dmem_resp = 1'b1;
    @(negedge clk); dmem_resp = 1'b0;
    #1;
    check_eq("stray_resp_res", res_valid, 0);
    check_eq("stray_resp_rw", {dmem_read, dmem_write}, 0);

    // Reset in the middle of a store.
    st_valid = 1'b1; st_memop = mem_sw; st_addr = 32'h30; st_wdata = 32'hDEAD_BEEF;
    #1 check_eq("rst_st_ready", st_ready, 1);
    @(negedge clk); st_valid = 1'b0;
    #1 check_eq("rst_st_write", dmem_write, 1);
    rst_n = 1'b0;
    @(negedge clk);
    #1 check_quiet("rst_mid_store");
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_eq("rst_post_write", dmem_write, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
